led_rate_sequencer: RTL and testbench

//  Control FSM for the LED blinker. Debounces two pushbuttons and drives the blinker's

---
 rtl/led_rate_sequencer_if.sv | 23 ++
 rtl/led_rate_sequencer.sv | 148 ++++++++++++++
 tb/tb_led_rate_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_rate_sequencer_if.sv
// Button inputs and blinker control outputs of the LED rate sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; the buttons are free-running levels and the outputs are levels or strobes.
// Ports: btn_run/btn_step are raw pushbuttons. rate_sel/blink_en/mode/step_pulse are the
//        blinker controls. master = button driver side, slave = sequencer side.
interface led_rate_sequencer_if;
  logic       btn_run;
  logic       btn_step;
  logic [1:0] rate_sel;
  logic       blink_en;
  logic [1:0] mode;
  logic       step_pulse;

  modport master (
    output btn_run, btn_step,
    input  rate_sel, blink_en, mode, step_pulse
  );

  modport slave (
    input  btn_run, btn_step,
    output rate_sel, blink_en, mode, step_pulse
  );
endinterface

// File: rtl/led_rate_sequencer.sv
// Debounces two pushbuttons and sequences the blinker mode (OFF/MANUAL/AUTO) and rate select.
// Latency: a press is acted on DEBOUNCE_CYC+2 edges after the first edge that samples it high.
// Backpressure: none; the buttons are free-running levels and the outputs are levels or strobes.
// Ports: clock (25 kHz), reset (async, active high), io.slave:
//        btn_run/btn_step in; rate_sel[1:0], blink_en, mode[1:0], step_pulse out.
module led_rate_sequencer #(
  parameter int DEBOUNCE_CYC  = 250,
  parameter int TICKS_PER_SEC = 25000,
  parameter int DWELL_SEC     = 2
) (
  input  logic clock,
  input  logic reset,
  led_rate_sequencer_if.slave io
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam int PS_W = $clog2(TICKS_PER_SEC);
  localparam int SC_W = (DWELL_SEC > 1) ? $clog2(DWELL_SEC) : 1;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    MANUAL = 2'b01,
    AUTO   = 2'b10
  } mode_e;

  // Index 0 = run button, index 1 = step button.
  logic [1:0]      raw;
  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      stable;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {io.btn_step, io.btn_run};

  // The counter only runs while the synchronized level disagrees with the accepted one.
  // Any agreeing sample restarts it, so a level is accepted only after DEBOUNCE_CYC
  // consecutive disagreeing samples. The press strobe fires on the accepting edge and
  // only for a rising level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      press  <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
          press[i]  <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic            run_p;
  logic            step_p;
  mode_e           mode_q;
  mode_e           mode_d;
  logic [1:0]      rate_q;
  logic [1:0]      rate_d;
  logic            step_q;
  logic            step_d;
  logic            en_q;
  logic            en_d;
  logic [PS_W-1:0] presc_q;
  logic [PS_W-1:0] presc_d;
  logic [SC_W-1:0] sec_q;
  logic [SC_W-1:0] sec_d;
  logic            dwell_done;
  logic            advance;

  assign run_p      = press[0];
  assign step_p     = press[1];
  assign dwell_done = (presc_q == PS_W'(TICKS_PER_SEC - 1)) && (sec_q == SC_W'(DWELL_SEC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q  <= OFF;
      rate_q  <= 2'b00;
      step_q  <= 1'b0;
      en_q    <= 1'b0;
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      step_q  <= step_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  // The dwell counters default to zero. This holds them clear outside AUTO and
  // on every AUTO advance, so entering AUTO always starts a fresh dwell.
  // A run press takes priority over a step press on the same cycle.
  always_comb begin
    mode_d  = mode_q;
    rate_d  = rate_q;
    step_d  = 1'b0;
    presc_d = '0;
    sec_d   = '0;
    advance = 1'b0;
    case (mode_q)
      OFF: begin
        if (run_p) mode_d = MANUAL;
      end
      MANUAL: begin
        if (run_p)       mode_d  = AUTO;
        else if (step_p) advance = 1'b1;
      end
      AUTO: begin
        if (run_p) begin
          mode_d = OFF;
        end else if (step_p || dwell_done) begin
          advance = 1'b1;
        end else if (presc_q == PS_W'(TICKS_PER_SEC - 1)) begin
          sec_d = sec_q + SC_W'(1);
        end else begin
          presc_d = presc_q + PS_W'(1);
          sec_d   = sec_q;
        end
      end
      default: mode_d = OFF;
    endcase
    if (advance) begin
      rate_d = rate_q + 2'd1;
      step_d = 1'b1;
    end
    en_d = (mode_d != OFF);
  end

  assign io.mode       = mode_q;
  assign io.rate_sel   = rate_q;
  assign io.blink_en   = en_q;
  assign io.step_pulse = step_q;

endmodule

// File: tb/tb_led_rate_sequencer.sv
// Randomized and directed bench for led_rate_sequencer with a queue-based scoreboard.
module tb_led_rate_sequencer;
  localparam int D     = 4;
  localparam int T     = 10;
  localparam int DW    = 2;
  localparam int DWELL = T * DW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  led_rate_sequencer_if bus();

  led_rate_sequencer #(
    .DEBOUNCE_CYC (D),
    .TICKS_PER_SEC(T),
    .DWELL_SEC    (DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus)
  );

  always #20 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [1:0] rate;
    logic       en;
    logic       pulse;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  cyc    = 0;

  // Reference model state. The debounce is modelled as a sliding window: a level is
  // accepted when the DEBOUNCE_CYC samples taken 2..D+1 edges ago all disagree with
  // the accepted level. A button press acts one edge after it is accepted. AUTO dwell
  // is modelled as one cycle count that advances the rate when it reaches DWELL.
  int             m_mode;
  int             m_rate;
  int             m_dwell;
  bit             m_stab [2];
  bit             m_pr   [2];
  bit             m_npr  [2];
  logic [D+1:0]   hist   [2];
  bit             smp    [2];
  int             om;
  int             orate;
  bit             adv;
  ev_t            ev;

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_mode  = 0;
        m_rate  = 0;
        m_dwell = 0;
        for (int b = 0; b < 2; b++) begin
          m_stab[b] = 0;
          m_pr[b]   = 0;
          hist[b]   = '0;
        end
      end else begin
        smp[0] = bus.btn_run;
        smp[1] = bus.btn_step;
        om     = m_mode;
        orate  = m_rate;
        adv    = 0;
        case (m_mode)
          0: if (m_pr[0]) m_mode = 1;
          1: begin
            if (m_pr[0])      m_mode = 2;
            else if (m_pr[1]) adv = 1;
          end
          default: begin
            if (m_pr[0])                               m_mode = 0;
            else if (m_pr[1] || m_dwell == DWELL - 1)  adv = 1;
            else                                       m_dwell++;
          end
        endcase
        if (adv) begin
          m_rate  = (m_rate + 1) % 4;
          m_dwell = 0;
        end
        if (m_mode != 2) m_dwell = 0;
        for (int b = 0; b < 2; b++) begin
          hist[b]  = {hist[b][D:0], smp[b]};
          m_npr[b] = 0;
          if (hist[b][D+1:2] == {D{~m_stab[b]}}) begin
            m_stab[b] = ~m_stab[b];
            m_npr[b]  = m_stab[b];
          end
          m_pr[b] = m_npr[b];
        end
        if (adv || m_mode != om || m_rate != orate) begin
          ev.cyc   = cyc;
          ev.mode  = 2'(m_mode);
          ev.rate  = 2'(m_rate);
          ev.en    = (m_mode != 0);
          ev.pulse = adv;
          exp_q.push_back(ev);
        end
      end
    end
  end

  // Monitor: any visible output change or strobe consumes one expected event.
  logic [1:0] pm;
  logic [1:0] prt;
  logic       pe;
  ev_t        e;

  initial begin
    pm = 0; prt = 0; pe = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        pm = 0; prt = 0; pe = 0;
      end else begin
        if (bus.step_pulse || bus.mode != pm || bus.rate_sel != prt || bus.blink_en != pe) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL spurious_event: got cyc=%0d mode=%0d rate=%0d en=%0d pulse=%0d, expected no event",
                     cyc, bus.mode, bus.rate_sel, bus.blink_en, bus.step_pulse);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc == cyc && e.mode == bus.mode && e.rate == bus.rate_sel &&
                e.en == bus.blink_en && e.pulse == bus.step_pulse) begin
              passed++;
            end else begin
              $display("FAIL event: got cyc=%0d mode=%0d rate=%0d en=%0d pulse=%0d, expected cyc=%0d mode=%0d rate=%0d en=%0d pulse=%0d",
                       cyc, bus.mode, bus.rate_sel, bus.blink_en, bus.step_pulse,
                       e.cyc, e.mode, e.rate, e.en, e.pulse);
            end
          end
        end
        pm  = bus.mode;
        prt = bus.rate_sel;
        pe  = bus.blink_en;
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  task automatic hold(input bit r, input bit s, input int n);
    bus.btn_run  = r;
    bus.btn_step = s;
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input bit r, input bit s, input int n);
    hold(r, s, n);
    hold(0, 0, D + 3);
  endtask

  initial begin
    bus.btn_run  = 0;
    bus.btn_step = 0;
    reset        = 1;
    repeat (3) @(negedge clock);
    chk("reset_mode", bus.mode, 0);
    chk("reset_rate", bus.rate_sel, 0);
    chk("reset_en", bus.blink_en, 0);
    chk("reset_pulse", bus.step_pulse, 0);
    reset = 0;
    hold(0, 0, 3);

    // Debounce: short glitches are ignored, a long press enters MANUAL.
    for (int i = 0; i < 3; i++) press(1, 0, $urandom_range(1, D - 1));
    chk("glitch_mode", bus.mode, 0);
    press(1, 0, 20);
    chk("long_press_mode", bus.mode, 1);

    // MANUAL wrap, then the same presses in OFF are ignored.
    for (int i = 0; i < 5; i++) press(0, 1, $urandom_range(D, 8));
    chk("manual_wrap_rate", bus.rate_sel, 1);
    press(1, 0, D);
    press(1, 0, D);
    chk("off_mode", bus.mode, 0);
    for (int i = 0; i < 5; i++) press(0, 1, $urandom_range(D, 8));
    chk("off_rate_hold", bus.rate_sel, 1);

    // AUTO timing from rate 01.
    for (int i = 0; i < 3 && m_mode != 1; i++) press(1, 0, D);
    for (int i = 0; i < 4 && m_rate != 1; i++) press(0, 1, D);
    press(1, 0, D);
    chk("auto_mode", bus.mode, 2);
    hold(0, 0, 65);

    // AUTO override partway through a dwell.
    for (int i = 0; i < 40 && m_dwell != 1; i++) @(negedge clock);
    press(0, 1, D);
    hold(0, 0, 25);
    chk("override_rate", bus.rate_sel, m_rate);

    // Simultaneous run and step in MANUAL at rate 10.
    for (int i = 0; i < 3 && m_mode != 1; i++) press(1, 0, D);
    for (int i = 0; i < 4 && m_rate != 2; i++) press(0, 1, D);
    press(1, 1, 6);
    chk("simul_mode", bus.mode, 2);
    chk("simul_rate", bus.rate_sel, 2);

    // Asynchronous reset mid-AUTO.
    hold(0, 0, 5);
    #3 reset = 1;
    #1;
    chk("async_rst_mode", bus.mode, 0);
    chk("async_rst_rate", bus.rate_sel, 0);
    chk("async_rst_en", bus.blink_en, 0);
    chk("async_rst_pulse", bus.step_pulse, 0);
    repeat (3) @(negedge clock);
    reset = 0;
    press(1, 0, D);
    chk("post_rst_mode", bus.mode, 1);
    chk("post_rst_rate", bus.rate_sel, 0);

    // Random button activity.
    for (int i = 0; i < 60; i++)
      hold(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom_range(1, 12));
    hold(0, 0, 30);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
